alu_issue_stage: RTL and testbench

//  Drives the alu. Accepts RV32I register/immediate ALU instructions with their operand values over a

---
 rtl/alu_pkg.sv | 88 ++++++++
 rtl/alu.sv | 32 +++
 rtl/alu_issue_stage.sv | 86 ++++++++
 tb/tb_alu_issue_stage.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU op encoding, RV32I field constants, S1 payload and decoder
// Contents:
//   alu_op_e    3-bit ALU operation
//   s1_t        decoded instruction held in the decode register
//   alu_decode  maps an RV32I word plus operand values onto an s1_t
package alu_pkg;

  localparam int XLEN_W = 32;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    alu_op_e             op;
    logic [XLEN_W-1:0]   a;
    logic [XLEN_W-1:0]   b;
    logic [4:0]          rd;
    logic                illegal;
  } s1_t;

  // funct3 values shared by the register and immediate forms
  function automatic logic f3_supported(input logic [2:0] f3, output alu_op_e op);
    logic ok;
    ok = 1'b1;
    op = ALU_ADD;
    case (f3)
      F3_ADD:  op = ALU_ADD;
      F3_AND:  op = ALU_AND;
      F3_OR:   op = ALU_OR;
      F3_XOR:  op = ALU_XOR;
      F3_SLT:  op = ALU_SLT;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic s1_t alu_decode(input logic [31:0]       instr,
                                     input logic [XLEN_W-1:0] rs1,
                                     input logic [XLEN_W-1:0] rs2);
    s1_t        d;
    alu_op_e    op;
    logic       ok;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    opc = instr[6:0];
    f3  = instr[14:12];
    f7  = instr[31:25];
    d.op      = ALU_ADD;
    d.a       = '0;
    d.b       = '0;
    d.rd      = instr[11:7];
    d.illegal = 1'b1;
    ok = f3_supported(f3, op);
    if (opc == OPC_OP) begin
      if (f7 == F7_BASE && ok) begin
        d.op = op; d.a = rs1; d.b = rs2; d.illegal = 1'b0;
      end else if (f7 == F7_ALT && f3 == F3_ADD) begin
        d.op = ALU_SUB; d.a = rs1; d.b = rs2; d.illegal = 1'b0;
      end
    end else if (opc == OPC_OP_IMM && ok) begin
      d.op      = op;
      d.a       = rs1;
      d.b       = {{(XLEN_W-12){instr[31]}}, instr[31:20]};
      d.illegal = 1'b0;
    end
    return d;
  endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational ALU
// Ports:
//   op      in   ALU operation
//   a, b    in   operands
//   result  out  op(a, b)
//   zero    out  result == 0
module alu
  import alu_pkg::*;
(
  input  alu_op_e           op,
  input  logic [XLEN_W-1:0] a,
  input  logic [XLEN_W-1:0] b,
  output logic [XLEN_W-1:0] result,
  output logic              zero
);

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLT: result = {{(XLEN_W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - two-stage decode/execute issue stage in front of the ALU
// Ports:
//   clk, rst_n, flush                         clock, async active-low reset, sync kill
//   in_valid/in_ready, in_instr, in_rs*_val   instruction intake
//   out_valid/out_ready, out_rd, out_result,
//   out_zero, out_illegal                     result toward writeback
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter bit PASS_ILLEGAL = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_result,
  output logic            out_zero,
  output logic            out_illegal
);

  s1_t             s1;
  logic            s1_valid;
  logic            s2_valid;
  logic            s1_ready;
  logic            s2_ready;
  logic            accept;
  s1_t             dec;
  logic [XLEN-1:0] alu_result;
  logic            alu_zero;

  assign s2_ready = !s2_valid || out_ready;
  assign s1_ready = !s1_valid || s2_ready;
  // a flushing cycle must not swallow a new instruction
  assign in_ready = s1_ready && !flush;
  assign accept   = in_valid && in_ready;
  assign dec      = alu_decode(in_instr, in_rs1_val, in_rs2_val);

  alu u_alu (
    .op     (s1.op),
    .a      (s1.a),
    .b      (s1.b),
    .result (alu_result),
    .zero   (alu_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1          <= '0;
      s2_valid    <= 1'b0;
      out_rd      <= '0;
      out_result  <= '0;
      out_zero    <= 1'b0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s1_ready) begin
        // illegal instrs are still handshaken in when dropping, just never occupy S1
        s1_valid <= accept && (PASS_ILLEGAL || !dec.illegal);
        if (accept) s1 <= dec;
      end
      if (s2_ready) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_rd      <= s1.rd;
          out_result  <= s1.illegal ? '0 : alu_result;
          out_zero    <= s1.illegal ? 1'b0 : alu_zero;
          out_illegal <= s1.illegal;
        end
      end
    end
  end

  assign out_valid = s2_valid;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - scoreboard bench for alu_issue_stage
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs1_val;
  logic [31:0] in_rs2_val;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rd;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_illegal;

  logic        d_in_valid;
  logic        d_in_ready;
  logic [31:0] d_in_instr;
  logic [31:0] d_in_rs1_val;
  logic [31:0] d_in_rs2_val;
  logic        d_out_valid;
  logic        d_out_ready;
  logic [4:0]  d_out_rd;
  logic [31:0] d_out_result;
  logic        d_out_zero;
  logic        d_out_illegal;

  always #5 clk = ~clk;

  alu_issue_stage #(.XLEN(32), .PASS_ILLEGAL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
    .out_result(out_result), .out_zero(out_zero), .out_illegal(out_illegal)
  );

  alu_issue_stage #(.XLEN(32), .PASS_ILLEGAL(1'b0)) dut_drop (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(d_in_valid), .in_ready(d_in_ready), .in_instr(d_in_instr),
    .in_rs1_val(d_in_rs1_val), .in_rs2_val(d_in_rs2_val),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .out_rd(d_out_rd),
    .out_result(d_out_result), .out_zero(d_out_zero), .out_illegal(d_out_illegal)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] res;
    logic        zero;
    logic        ill;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h40208233;
  localparam logic [31:0] I_SLTI = 32'hFFF0A293;
  localparam logic [31:0] I_SLL  = 32'h002090B3;
  localparam logic [31:0] I_AND  = 32'h0020F333;
  localparam logic [31:0] I_ADDI = 32'hFFD08393;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [4:0] rd, input logic [31:0] res,
                              input logic zero, input logic ill);
    exp_t e;
    e.rd = rd; e.res = res; e.zero = zero; e.ill = ill;
    return e;
  endfunction

  // scoreboard: every output transfer must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL unexpected_out observed=rd %0d result %h expected=no output", out_rd, out_result);
      end else begin
        mon_e = q.pop_front();
        check("sb_rd", {27'd0, out_rd}, {27'd0, mon_e.rd});
        check("sb_result", out_result, mon_e.res);
        check("sb_zero", {31'd0, out_zero}, {31'd0, mon_e.zero});
        check("sb_illegal", {31'd0, out_illegal}, {31'd0, mon_e.ill});
      end
    end
  end

  task automatic send(input logic [31:0] instr, input logic [31:0] a,
                      input logic [31:0] b, input exp_t e);
    int n;
    in_instr = instr; in_rs1_val = a; in_rs2_val = b; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("send_accept", {31'd0, in_ready}, 32'd1);
    if (in_ready) begin
      @(posedge clk);
      q.push_back(e);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  int          cnt;
  logic [4:0]  seen_rd;
  logic [31:0] seen_res;
  logic        seen_ill;

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_rs1_val = '0; in_rs2_val = '0;
    d_in_valid = 1'b0; d_out_ready = 1'b1; d_in_instr = '0; d_in_rs1_val = '0; d_in_rs2_val = '0;
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_rd", {27'd0, out_rd}, 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_zero", {31'd0, out_zero}, 32'd0);
    check("rst_out_illegal", {31'd0, out_illegal}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // 1: ADD with latency check
    out_ready = 1'b1;
    send(I_ADD, 32'd5, 32'd3, mk(5'd3, 32'd8, 1'b0, 1'b0));
    check("lat_after_accept", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("lat_next_edge", {31'd0, out_valid}, 32'd1);
    drain();

    // 2/3: SUB zero, SLTI both ways, AND, ADDI negative immediate
    send(I_SUB, 32'd2, 32'd2, mk(5'd4, 32'd0, 1'b1, 1'b0));
    send(I_SLTI, 32'hFFFFFFFB, 32'h12345678, mk(5'd5, 32'd1, 1'b0, 1'b0));
    send(I_SLTI, 32'd1, 32'd0, mk(5'd5, 32'd0, 1'b1, 1'b0));
    send(I_AND, 32'h0000F0F0, 32'h0000FF00, mk(5'd6, 32'h0000F000, 1'b0, 1'b0));
    send(I_ADDI, 32'd10, 32'hFFFFFFFF, mk(5'd7, 32'd7, 1'b0, 1'b0));
    drain();

    // 4: backpressure with both stages full
    out_ready = 1'b0;
    send(I_ADD, 32'd1, 32'd2, mk(5'd3, 32'd3, 1'b0, 1'b0));
    send(I_ADD, 32'd10, 32'd20, mk(5'd3, 32'd30, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      check("stall_out_result", out_result, 32'd3);
      check("stall_out_rd", {27'd0, out_rd}, 32'd3);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(I_ADD, 32'd100, 32'd200, mk(5'd3, 32'd300, 1'b0, 1'b0));
    send(I_ADD, 32'hFFFFFFFF, 32'd1, mk(5'd3, 32'd0, 1'b1, 1'b0));
    drain();

    // 5: illegal passes through with result forced to 0
    send(I_SLL, 32'd7, 32'd1, mk(5'd1, 32'd0, 1'b0, 1'b1));
    send(I_ADD, 32'd4, 32'd4, mk(5'd3, 32'd8, 1'b0, 1'b0));
    drain();

    // 5b: dropping instance swallows the illegal instr
    d_in_valid = 1'b1; d_in_instr = I_SLL; d_in_rs1_val = 32'd7; d_in_rs2_val = 32'd1;
    @(negedge clk);
    check("drop_ready_ill", {31'd0, d_in_ready}, 32'd1);
    @(posedge clk);
    #1;
    d_in_instr = I_ADD; d_in_rs1_val = 32'd5; d_in_rs2_val = 32'd3;
    @(negedge clk);
    check("drop_ready_add", {31'd0, d_in_ready}, 32'd1);
    @(posedge clk);
    #1;
    d_in_valid = 1'b0;
    cnt = 0; seen_rd = '0; seen_res = '0; seen_ill = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (d_out_valid) begin
        cnt++;
        seen_rd = d_out_rd; seen_res = d_out_result; seen_ill = d_out_illegal;
      end
    end
    check("drop_count", cnt, 32'd1);
    check("drop_rd", {27'd0, seen_rd}, 32'd3);
    check("drop_result", seen_res, 32'd8);
    check("drop_illegal", {31'd0, seen_ill}, 32'd0);
    @(posedge clk);
    #1;

    // 6a: flush kills in-flight instrs and blocks same-cycle intake
    out_ready = 1'b0;
    send(I_ADD, 32'd11, 32'd11, mk(5'd3, 32'd22, 1'b0, 1'b0));
    send(I_ADD, 32'd12, 32'd12, mk(5'd3, 32'd24, 1'b0, 1'b0));
    flush = 1'b1; in_valid = 1'b1; in_instr = I_ADD; in_rs1_val = 32'd9; in_rs2_val = 32'd9;
    #1;
    check("flush_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    q.delete();
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("flush_quiet", {31'd0, out_valid}, 32'd0);
    end
    send(I_ADD, 32'd6, 32'd7, mk(5'd3, 32'd13, 1'b0, 1'b0));
    drain();

    // 6b: async reset mid-stream
    out_ready = 1'b0;
    send(I_ADD, 32'd1, 32'd1, mk(5'd3, 32'd2, 1'b0, 1'b0));
    send(I_SUB, 32'd9, 32'd1, mk(5'd4, 32'd8, 1'b0, 1'b0));
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_out_rd", {27'd0, out_rd}, 32'd0);
    check("arst_out_result", out_result, 32'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("arst_quiet", {31'd0, out_valid}, 32'd0);
    send(I_ADD, 32'd20, 32'd22, mk(5'd3, 32'd42, 1'b0, 1'b0));
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=still running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
